// File: rtl/irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// irq_ctrl_pkg
// Shared definitions for the Wishbone interrupt controller:
//   - register word offsets (wb_addr_i[4:2])
//   - claim FSM state encoding
//   - source id width (id 0 means "no source")
// ---------------------------------------------------------------------------
package irq_ctrl_pkg;

  localparam int ID_W = 5;

  localparam logic [2:0] ADDR_PENDING = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_MODE    = 3'd2;
  localparam logic [2:0] ADDR_CLAIM   = 3'd3;
  localparam logic [2:0] ADDR_STATUS  = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// ---------------------------------------------------------------------------
// irq_prio_enc
// Fixed-priority encoder: o_id = 1 + lowest set index of i_req, 0 if none.
// Ports:
//   i_req  [N_SRC-1:0]  request vector (pending & enable)
//   o_id   [ID_W-1:0]   winning source id, 0 = none
// ---------------------------------------------------------------------------
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] i_req,
  output logic [ID_W-1:0]  o_id
);

  // Scan from the highest index down so the lowest set index wins last.
  always_comb begin
    o_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_id = ID_W'(i + 1);
      end else begin
        o_id = o_id;
      end
    end
  end

endmodule

// File: rtl/wb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// wb_irq_ctrl
// Wishbone-slave interrupt controller. Latches, masks and prioritises N_SRC
// sources (source 0 = timer) and raises irq_o; one source is serviced at a
// time through a CLAIM read / CLAIM write (complete) handshake.
// Optional feature macro: IRQ_CTRL_EDGE_EN (MODE register + edge latching).
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   wb_addr_i/wb_data_i/...    Wishbone slave; word select wb_addr_i[4:2]
//   wb_ack_o, wb_data_o        registered single-cycle ack and read data
//   timer_irq_i, ext_irq_i     interrupt sources (synchronous to clk_i)
//   irq_o                      registered interrupt request to the core
// ---------------------------------------------------------------------------
module wb_irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int WB_DATA_WIDTH = 32,
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_SEL_WIDTH  = 4,
  parameter int N_SRC         = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
  input  logic                     wb_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_cyc_i,
  output logic                     wb_ack_o,
  output logic [WB_DATA_WIDTH-1:0] wb_data_o,
  input  logic                     timer_irq_i,
  input  logic [N_SRC-2:0]         ext_irq_i,
  output logic                     irq_o
);

  localparam logic [N_SRC-1:0] ONE_HOT0 = {{(N_SRC-1){1'b0}}, 1'b1};

  // Byte selects and non-word address bits carry no information here.
  logic w_unused;
  assign w_unused = &{1'b0, wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:5], wb_addr_i[1:0]};

  logic [N_SRC-1:0]         w_src_in;
  logic [N_SRC-1:0]         r_src_q;
  logic [N_SRC-1:0]         r_enable;
  logic [N_SRC-1:0]         w_pending;
  logic [N_SRC-1:0]         w_mode_rd;
  logic [ID_W-1:0]          w_id;
  logic [ID_W-1:0]          r_isr_id;
  logic [ID_W-1:0]          w_isr_id_next;
  irq_state_e               r_state;
  irq_state_e               w_state_next;
  logic                     r_ack;
  logic [WB_DATA_WIDTH-1:0] r_data;
  logic [WB_DATA_WIDTH-1:0] w_rdata;
  logic                     r_irq;
  logic                     w_access;
  logic                     w_wr;
  logic                     w_rd;
  logic [2:0]               w_addr;
  logic                     w_claim;
  logic                     w_complete;

  assign w_src_in = {ext_irq_i, timer_irq_i};
  // An access is accepted only while ack is low, giving one ack per access.
  assign w_access = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_wr     = w_access & wb_we_i;
  assign w_rd     = w_access & ~wb_we_i;
  assign w_addr   = wb_addr_i[4:2];

  assign w_claim    = w_rd && (w_addr == ADDR_CLAIM) && (r_state == ST_IDLE) && (w_id != '0);
  assign w_complete = w_wr && (w_addr == ADDR_CLAIM) && (r_state == ST_BUSY) &&
                      (wb_data_i == {{(WB_DATA_WIDTH-ID_W){1'b0}}, r_isr_id});

`ifdef IRQ_CTRL_EDGE_EN
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_pend_edge;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_clr;

  // Rising edge of src_q seen at the edge that loads it.
  assign w_rise    = w_src_in & ~r_src_q;
  assign w_pending = (r_mode & r_pend_edge) | (~r_mode & r_src_q);
  assign w_mode_rd = r_mode;

  // Clear requests from W1C and claim; only edge-mode bits are clearable.
  always_comb begin
    w_clr = '0;
    if (w_wr && (w_addr == ADDR_PENDING)) begin
      w_clr = wb_data_i[N_SRC-1:0];
    end else if (w_claim) begin
      w_clr = ONE_HOT0 << (w_id - 5'd1);
    end else begin
      w_clr = '0;
    end
  end

  // MODE register and edge-latched pending bits; a new edge beats a clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mode      <= '0;
      r_pend_edge <= '0;
    end else begin
      if (w_wr && (w_addr == ADDR_MODE)) begin
        r_mode <= wb_data_i[N_SRC-1:0];
      end else begin
        r_mode <= r_mode;
      end
      r_pend_edge <= ((r_pend_edge & ~(w_clr & r_mode)) | w_rise) & r_mode;
    end
  end
`else
  assign w_pending = r_src_q;
  assign w_mode_rd = '0;
`endif

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .i_req (w_pending & r_enable),
    .o_id  (w_id)
  );

  // Register read mux; undefined words and unused bits read as zero.
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_PENDING: w_rdata[N_SRC-1:0] = w_pending;
      ADDR_ENABLE:  w_rdata[N_SRC-1:0] = r_enable;
      ADDR_MODE:    w_rdata[N_SRC-1:0] = w_mode_rd;
      ADDR_CLAIM:   w_rdata[ID_W-1:0]  = (r_state == ST_IDLE) ? w_id : 5'd0;
      ADDR_STATUS: begin
        w_rdata[0]    = (r_state == ST_BUSY);
        w_rdata[12:8] = r_isr_id;
      end
      default:      w_rdata = '0;
    endcase
  end

  // Claim FSM next-state: claim enters BUSY, matching complete returns to IDLE.
  always_comb begin
    w_state_next  = r_state;
    w_isr_id_next = r_isr_id;
    case (r_state)
      ST_IDLE: begin
        if (w_claim) begin
          w_state_next  = ST_BUSY;
          w_isr_id_next = w_id;
        end else begin
          w_state_next  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_complete) begin
          w_state_next  = ST_IDLE;
          w_isr_id_next = '0;
        end else begin
          w_state_next  = ST_BUSY;
        end
      end
      default: begin
        w_state_next  = ST_IDLE;
        w_isr_id_next = '0;
      end
    endcase
  end

  // State, bus, source and enable registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_isr_id <= '0;
      r_ack    <= 1'b0;
      r_data   <= '0;
      r_irq    <= 1'b0;
      r_src_q  <= '0;
      r_enable <= '0;
    end else begin
      r_state  <= w_state_next;
      r_isr_id <= w_isr_id_next;
      r_ack    <= w_access;
      r_data   <= w_rd ? w_rdata : '0;
      r_irq    <= (r_state == ST_IDLE) && (|(w_pending & r_enable));
      r_src_q  <= w_src_in;
      if (w_wr && (w_addr == ADDR_ENABLE)) begin
        r_enable <= wb_data_i[N_SRC-1:0];
      end else begin
        r_enable <= r_enable;
      end
    end
  end

  assign wb_ack_o  = r_ack;
  assign wb_data_o = r_data;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_wb_irq_ctrl.sv
module tb_wb_irq_ctrl;
  localparam int N = 8;
`ifdef IRQ_CTRL_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] wb_addr_i = 32'd0;
  logic [31:0] wb_data_i = 32'd0;
  logic        wb_we_i = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] wb_data_o;
  logic        timer_irq_i = 1'b0;
  logic [N-2:0] ext_irq_i = '0;
  logic        irq_o;

  wb_irq_ctrl #(.WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32), .WB_SEL_WIDTH(4), .N_SRC(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .wb_data_o(wb_data_o), .timer_irq_i(timer_irq_i),
    .ext_irq_i(ext_irq_i), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [N-1:0] m_srcq, m_epend, m_en, m_mode;
  bit           m_busy;
  logic [4:0]   m_isr;
  bit           m_irq, m_ack;
  logic [31:0]  rd_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, clock, compare.
  task automatic do_cycle(input bit cyc, input bit we, input logic [2:0] a,
                          input logic [31:0] wd, input bit rst);
    logic [N-1:0] new_src, pend, pe, clr, rise;
    logic [4:0]   id;
    logic [31:0]  exp_rd;
    bit           acc;
    rst_ni    = ~rst;
    wb_cyc_i  = cyc;
    wb_stb_i  = cyc;
    wb_we_i   = we;
    wb_addr_i = {27'd0, a, 2'b00};
    wb_data_i = wd;
    new_src = {ext_irq_i, timer_irq_i};
    pend = (m_mode & m_epend) | (~m_mode & m_srcq);
    pe = pend & m_en;
    id = 5'd0;
    for (int i = 0; i < N; i++) if (pe[i] && id == 5'd0) id = 5'(i + 1);
    acc = cyc && !m_ack;
    exp_rd = 32'd0;
    case (a)
      3'd0: exp_rd = {24'd0, pend};
      3'd1: exp_rd = {24'd0, m_en};
      3'd2: exp_rd = {24'd0, m_mode};
      3'd3: exp_rd = m_busy ? 32'd0 : {27'd0, id};
      3'd4: exp_rd = {19'd0, m_isr, 7'd0, m_busy};
      default: exp_rd = 32'd0;
    endcase
    @(posedge clk_i);
    #1;
    if (rst) begin
      m_srcq = '0; m_epend = '0; m_en = '0; m_mode = '0;
      m_busy = 1'b0; m_isr = 5'd0; m_irq = 1'b0; m_ack = 1'b0;
      chk("rst_data", wb_data_o, 32'd0);
    end else begin
      clr = '0;
      m_irq = !m_busy && (pe != '0);
      if (acc && !we && a == 3'd3 && !m_busy && id != 5'd0) begin
        m_busy = 1'b1; m_isr = id; clr[id - 5'd1] = 1'b1;
      end
      if (acc && we && a == 3'd3 && m_busy && wd == {27'd0, m_isr}) begin
        m_busy = 1'b0; m_isr = 5'd0;
      end
      if (acc && we && a == 3'd0) clr = wd[N-1:0];
      rise = new_src & ~m_srcq;
      m_epend = ((m_epend & ~(clr & m_mode)) | rise) & m_mode;
      if (acc && we && a == 3'd1) m_en = wd[N-1:0];
      if (acc && we && a == 3'd2 && EDGE) m_mode = wd[N-1:0];
      m_srcq = new_src;
      m_ack = acc;
      if (acc && !we) chk("rd_data", wb_data_o, exp_rd);
    end
    chk("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
    chk("irq", {31'd0, irq_o}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic rd(input logic [2:0] a);
    do_cycle(1'b1, 1'b0, a, 32'd0, 1'b0);
    rd_val = wb_data_o;
    idle(1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    do_cycle(1'b1, 1'b1, a, d, 1'b0);
    idle(1);
  endtask

  initial begin
    m_srcq = '0; m_epend = '0; m_en = '0; m_mode = '0;
    m_busy = 1'b0; m_isr = 5'd0; m_irq = 1'b0; m_ack = 1'b0; rd_val = 32'd0;

    // Reset
    do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    idle(1);

    // Timer interrupt, claim and complete
    wr(3'd1, 32'h01);
    timer_irq_i = 1'b1;
    idle(2);
    chk("timer_irq", {31'd0, irq_o}, 32'd1);
    rd(3'd3);
    chk("claim_timer", rd_val, 32'd1);
    chk("irq_busy", {31'd0, irq_o}, 32'd0);
    timer_irq_i = 1'b0;
    wr(3'd3, 32'd1);
    rd(3'd4);
    chk("status_idle", rd_val, 32'd0);

    // Priority among ext sources, claim while busy, re-claim after complete
    wr(3'd1, 32'h0C);
    ext_irq_i = 7'b0000110;
    idle(2);
    rd(3'd3);
    chk("claim_prio", rd_val, 32'd3);
    rd(3'd3);
    chk("claim_busy", rd_val, 32'd0);
    wr(3'd3, 32'd3);
    rd(3'd3);
    chk("claim_again", rd_val, 32'd3);
    wr(3'd3, 32'd3);

    // Wrong completion id, then reset mid-BUSY
    ext_irq_i = 7'b0000001;
    wr(3'd1, 32'h02);
    idle(1);
    rd(3'd3);
    chk("claim_id2", rd_val, 32'd2);
    wr(3'd3, 32'd5);
    rd(3'd4);
    chk("status_wrong_cpl", rd_val, 32'h0000_0201);
    do_cycle(1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    rd(3'd4);
    chk("status_after_rst", rd_val, 32'd0);
    chk("irq_after_rst", {31'd0, irq_o}, 32'd0);

    // Undefined address and back-to-back ack
    rd(3'd6);
    chk("undef_rd", rd_val, 32'd0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 3'd1, 32'd0, 1'b0);
    idle(1);

    // All sources high but disabled
    wr(3'd1, 32'h00);
    timer_irq_i = 1'b1;
    ext_irq_i = 7'h7F;
    idle(3);
    chk("irq_disabled", {31'd0, irq_o}, 32'd0);
    timer_irq_i = 1'b0;
    ext_irq_i = '0;
    idle(2);

`ifdef IRQ_CTRL_EDGE_EN
    // Edge latching, W1C, and set-beats-clear
    wr(3'd2, 32'h02);
    ext_irq_i = 7'b0000001;
    idle(1);
    ext_irq_i = 7'b0000000;
    idle(3);
    rd(3'd0);
    chk("edge_held", rd_val, 32'h02);
    wr(3'd0, 32'h02);
    rd(3'd0);
    chk("edge_w1c", rd_val, 32'h00);
    wr(3'd0, 32'h02);
    rd(3'd0);
    chk("edge_w1c_again", rd_val, 32'h00);
    ext_irq_i = 7'b0000001;
    do_cycle(1'b1, 1'b1, 3'd0, 32'h02, 1'b0);
    ext_irq_i = 7'b0000000;
    idle(1);
    rd(3'd0);
    chk("edge_set_beats_clr", rd_val, 32'h02);
`else
    // Without edge support MODE is read-only zero
    wr(3'd2, 32'hFF);
    rd(3'd2);
    chk("mode_ro", rd_val, 32'h00);
`endif

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [2:0]  a;
      logic [31:0] d;
      bit          we;
      if ($urandom_range(0, 3) == 0) begin
        timer_irq_i = 1'($urandom_range(0, 1));
        ext_irq_i   = 7'($urandom);
      end
      a  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (a == 3'd3) d = ($urandom_range(0, 1) == 1) ? {27'd0, m_isr} : {27'd0, 5'($urandom_range(0, 9))};
      if ($urandom_range(0, 1) == 1) do_cycle(1'b1, we, a, d, 1'b0);
      else do_cycle(1'b0, 1'b0, 3'd0, 32'd0, ($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
